// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the data-memory access unit and its helpers.
//   - mau_state_e : access FSM state encoding
//   - DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   - DEPTH_DEF   : default word count; must match the data memory row count
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mau_state_e;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

endpackage

// File: rtl/mau_lat_counter.sv
// mau_lat_counter: read-latency counter for the memory access unit.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the count (asserted on request accept)
//   load     : a load access is in progress this cycle; advance the count
//   done     : current cycle is the last ACCESS cycle of a load
// The count saturates at RD_LAT-1 instead of wrapping.
module mau_lat_counter #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    output logic done
);

    if (RD_LAT < 1) begin : g_bad_lat
        $error("mau_lat_counter: RD_LAT must be >= 1");
    end

    localparam int            CW   = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(RD_LAT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (load && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the data-memory port. Accepts one
// load/store at a time from the MEM stage, drives the memory strobes for the
// required number of cycles and returns a response.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake; req_we, req_addr, req_wdata
//   rsp_valid/rsp_ready : response handshake; rsp_rdata, rsp_err
//   busy                : FSM not idle
//   mem_access_addr, mem_write_data, mem_write_en, mem_read : memory side
//   mem_read_data       : memory read data, valid RD_LAT cycles after mem_read
// Build option MAU_RANGE_CHECK_EN: requests with req_addr >= DEPTH skip the
// memory and return rsp_err = 1. Without it rsp_err is always 0.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = 1,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("mem_access_unit: DEPTH must be >= 1");
    end

    mau_state_e        state, state_n;
    logic              accept;
    logic              addr_bad;
    logic              lat_done;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

`ifdef MAU_RANGE_CHECK_EN
    assign addr_bad = (req_addr >= ADDR_W'(DEPTH));
`else
    // Out-of-range addresses wrap in the memory's own decode.
    assign addr_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    // A bad address never touches memory.
                    state_n = addr_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (we_q || lat_done)
                    state_n = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request fields are held from accept until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            err_q   <= addr_bad;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
        end else if (mem_read && lat_done) begin
            rdata_q <= mem_read_data;
        end
    end

    mau_lat_counter #(.RD_LAT(RD_LAT)) u_lat (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .load  (mem_read),
        .done  (lat_done)
    );

    // Strobes decode straight from state so an async reset drops them at once.
    assign mem_write_en    = (state == ACCESS) &&  we_q;
    assign mem_read        = (state == ACCESS) && !we_q;
    assign mem_access_addr = addr_q;
    assign mem_write_data  = wdata_q;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;

`ifdef MAU_RANGE_CHECK_EN
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;
    int          sel = 0;

    logic        rv[2], rdy[2], rsp_v[2], err[2], bsy[2], mwe[2], mrd[2];
    logic [15:0] rdata[2], maddr[2], mwd[2], mrdata[2];

    int total = 0;
    int bad   = 0;
    logic [16:0] sb_q[$];
    logic [15:0] ref_mem[2][8] = '{default: '0};

    always #5 clk = ~clk;

    assign rv[0] = req_valid && (sel == 0);
    assign rv[1] = req_valid && (sel == 1);

    mem_access_unit #(.RD_LAT(1)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_v[0]),
        .rsp_ready(rsp_ready && sel == 0), .rsp_rdata(rdata[0]), .rsp_err(err[0]),
        .busy(bsy[0]), .mem_access_addr(maddr[0]), .mem_write_data(mwd[0]),
        .mem_write_en(mwe[0]), .mem_read(mrd[0]), .mem_read_data(mrdata[0])
    );

    mem_access_unit #(.RD_LAT(3)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_v[1]),
        .rsp_ready(rsp_ready && sel == 1), .rsp_rdata(rdata[1]), .rsp_err(err[1]),
        .busy(bsy[1]), .mem_access_addr(maddr[1]), .mem_write_data(mwd[1]),
        .mem_write_en(mwe[1]), .mem_read(mrd[1]), .mem_read_data(mrdata[1])
    );

    // Memory models: 8 words, low-bit decode, data valid only in the
    // RD_LAT-th cycle of mem_read (0xDEAD otherwise).
    logic [15:0] mem0[8] = '{default: '0};
    logic [15:0] mem1[8] = '{default: '0};
    int rc0 = 0, rc1 = 0;
    always @(posedge clk) begin
        if (mwe[0]) mem0[maddr[0][2:0]] <= mwd[0];
        rc0 <= mrd[0] ? rc0 + 1 : 0;
    end
    always @(posedge clk) begin
        if (mwe[1]) mem1[maddr[1][2:0]] <= mwd[1];
        rc1 <= mrd[1] ? rc1 + 1 : 0;
    end
    assign mrdata[0] = (rc0 == 0) ? mem0[maddr[0][2:0]] : 16'hDEAD;
    assign mrdata[1] = (rc1 == 2) ? mem1[maddr[1][2:0]] : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    function automatic logic range_bad(input logic [15:0] a);
`ifdef MAU_RANGE_CHECK_EN
        return (a >= 16'd8);
`else
        return (a != a);
`endif
    endfunction

    task automatic pop_check();
        logic [16:0] e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("rsp_rdata", 32'(rdata[sel]), 32'(e[15:0]));
            chk("rsp_err", 32'(err[sel]), 32'(e[16]));
        end
    endtask

    // One transaction on DUT 'sel': checks strobes, latency, hold and handshake.
    task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       input int hold);
        logic        e_err;
        logic [15:0] e_dat, snap;
        int          e_lat, e_rd, cyc, nwe, nrd;
        e_err = range_bad(addr);
        e_dat = (we || e_err) ? 16'h0 : ref_mem[sel][addr[2:0]];
        if (we && !e_err) ref_mem[sel][addr[2:0]] = wd;
        e_rd  = (we || e_err) ? 0 : ((sel == 0) ? 1 : 3);
        e_lat = (we || e_err) ? 1 : e_rd;

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        cyc = 0;
        while (!rdy[sel] && cyc < 20) begin @(negedge clk); cyc++; end
        chk("accept_ready", 32'(rdy[sel]), 32'd1);
        @(posedge clk);
        sb_q.push_back({e_err, e_dat});
        @(negedge clk);
        req_valid = 1'b0;
        nwe = 0; nrd = 0; cyc = 1;
        while (!rsp_v[sel] && cyc < 20) begin
            if (mwe[sel]) begin
                nwe++;
                chk("wr_addr", 32'(maddr[sel]), 32'(addr));
                chk("wr_data", 32'(mwd[sel]), 32'(wd));
            end
            if (mrd[sel]) nrd++;
            if (mwe[sel] && mrd[sel]) chk("both_strobes", 32'd1, 32'd0);
            @(negedge clk); cyc++;
        end
        chk("rsp_latency", 32'(cyc - 1), 32'(e_lat));
        chk("we_cycles", 32'(nwe), 32'((we && !e_err) ? 1 : 0));
        chk("rd_cycles", 32'(nrd), 32'(e_rd));
        chk("strobes_in_resp", 32'({mwe[sel], mrd[sel]}), 32'd0);
        snap = rdata[sel];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_v[sel]), 32'd1);
            chk("hold_rdata", 32'(rdata[sel]), 32'(snap));
            chk("hold_ready", 32'(rdy[sel]), 32'd0);
        end
        rsp_ready = 1'b1;
        pop_check();
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_ready", 32'(rdy[sel]), 32'd1);
        chk("post_valid", 32'(rsp_v[sel]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state of both instances
        #12;
        for (int d = 0; d < 2; d++) begin
            sel = d;
            chk("rst_ready", 32'(rdy[d]), 32'd1);
            chk("rst_outs", 32'({rsp_v[d], err[d], bsy[d], mwe[d], mrd[d]}), 32'd0);
            chk("rst_data", 32'({rdata[d], maddr[d]}), 32'd0);
            chk("rst_wdata", 32'(mwd[d]), 32'd0);
        end
        @(negedge clk); rst = 1'b0;

        // RD_LAT = 1: store, load back, load with back-pressure
        sel = 0;
        txn(1'b1, 16'd3, 16'hA5A5, 0);
        txn(1'b0, 16'd3, 16'h0000, 0);
        txn(1'b0, 16'd3, 16'h0000, 5);

        // RD_LAT = 3
        sel = 1;
        txn(1'b1, 16'd3, 16'hA5A5, 0);
        txn(1'b0, 16'd3, 16'h0000, 5);

        // Reset during the second ACCESS cycle of a RD_LAT = 3 load
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd3;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_outs", 32'({rsp_v[1], bsy[1], mwe[1], mrd[1]}), 32'd0);
        chk("abort_ready", 32'(rdy[1]), 32'd1);
        chk("abort_addr", 32'(maddr[1]), 32'd0);
        @(negedge clk); rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (rsp_v[1] || bsy[1]) seen++;
            end
            chk("abort_no_rsp", 32'(seen), 32'd0);
        end
        txn(1'b1, 16'd5, 16'h1234, 0);
        txn(1'b0, 16'd5, 16'h0000, 1);

        // Address 8: error with range check, wraps to word 0 without it
        sel = 0;
        txn(1'b1, 16'd0, 16'h0F0F, 0);
        txn(1'b0, 16'd8, 16'h0000, 0);
        txn(1'b1, 16'd9, 16'hBEEF, 0);
        txn(1'b0, 16'd1, 16'h0000, 0);

        // Mixed traffic on both instances
        for (int i = 0; i < 16; i++) begin
            sel = i % 2;
            txn(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)),
                16'($urandom), $urandom_range(0, 2));
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
